// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART transmit scheduler.
// UART_TX_PARITY_EN adds an even-parity bit, giving an 11-bit frame.
package uart_pkg;

  typedef enum logic {IDLE, SEND} state_t;

  localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: tick on the last cycle of each CLK_DIV-cycle bit, 0-cycle tick latency.
// Counts only while en is high; clears whenever en is low, so the first bit is always full length.
module uart_baud_gen #(
  parameter int CLK_DIV = 5208
) (
  input  logic clk_50M,
  input  logic reset,
  input  logic en,
  output logic tick
);

  logic [12:0] cnt;

  assign tick = en && (cnt == 13'(CLK_DIV - 1));

  always_ff @(posedge clk_50M) begin
    if (reset || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 13'd1;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter feeding one UART tx line; grant is combinational (0-cycle req_ready), data captured on the edge.
// Requests are not accepted while a frame is in flight; UART_TX_PARITY_EN selects the 11-bit parity frame.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 5208,
  parameter int NREQ    = 4
) (
  input  logic                      clk_50M,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [8*NREQ-1:0]         req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      tx,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id
);

  localparam int IW = $clog2(NREQ);

  state_t                state;
  state_t                state_nxt;
  logic [IW-1:0]         last;
  logic [IW-1:0]         pick;
  logic [IW-1:0]         idx;
  logic                  found;
  logic                  accept;
  logic                  tick;
  logic                  frame_done;
  logic [3:0]            bit_idx;
  logic [DATA_BITS-1:0]  pick_dat;
  logic [FRAME_BITS-1:0] shreg;

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk_50M (clk_50M),
    .reset   (reset),
    .en      (state == SEND),
    .tick    (tick)
  );

  // Scan last+1, last+2, ... so the most recent winner is checked last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign pick_dat   = req_data[{pick, 3'b000} +: DATA_BITS];
  assign frame_done = tick && (bit_idx == 4'(FRAME_BITS - 1));
  assign tx         = shreg[0];

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = SEND;
      SEND:    if (frame_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = 1'b0;
    accept    = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (found) begin
            accept          = 1'b1;
            req_ready[pick] = 1'b1;
            busy            = 1'b1;
          end
        end
        SEND:    busy = 1'b1;
        default: busy = 1'b0;
      endcase
    end
  end

  // Shift register idles at all-ones so tx rests high; ones fill in behind the stop bit.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      last     <= IW'(NREQ - 1);
      grant_id <= '0;
      shreg    <= '1;
      bit_idx  <= '0;
    end else if (accept) begin
      last     <= pick;
      grant_id <= pick;
      bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
      shreg    <= {1'b1, ^pick_dat, pick_dat, 1'b0};
`else
      shreg    <= {1'b1, pick_dat, 1'b0};
`endif
    end else if (state == SEND && tick) begin
      shreg   <= {1'b1, shreg[FRAME_BITS-1:1]};
      bit_idx <= bit_idx + 4'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler (CLK_DIV=4, NREQ=4) against a round-robin/frame reference model.
module tb_uart_tx_scheduler;

  localparam int CLK_DIV = 4;
  localparam int NREQ    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk_50M = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx;
  logic        busy;
  logic [1:0]  grant_id;

  int total = 0;
  int bad   = 0;
  int m_last;

  uart_tx_scheduler #(.CLK_DIV(CLK_DIV), .NREQ(NREQ)) dut (
    .clk_50M   (clk_50M),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Round-robin rule: first requester with valid high, starting just after the last winner.
  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // Bit k of a frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Called at a negedge in IDLE with inputs already set; returns at the following idle-cycle negedge.
  task automatic one_frame(input bit drop, input bit scramble);
    int p;
    logic [7:0] b;
    #1;
    p = rr_pick(req_valid, m_last);
    chk("tx_idle", tx, 1);
    chk("ready_acc", req_ready, 32'(1) << p);
    chk("busy_acc", busy, 1);
    b = req_data[8*p +: 8];
    m_last = p;
    @(posedge clk_50M);
    for (int c = 0; c < FB*CLK_DIV; c++) begin
      @(negedge clk_50M);
      chk("tx_bit", tx, fbit(b, c / CLK_DIV));
      chk("busy_send", busy, 1);
      chk("ready_send", req_ready, 0);
      if (c == 0) begin
        chk("grant_id", grant_id, p);
        if (drop) req_valid[p] = 1'b0;
        else req_data[8*p +: 8] = 8'($urandom);
      end
      if (scramble && (c % 3 == 0)) begin
        req_data  = $urandom;
        req_valid = 4'($urandom);
      end
    end
    @(negedge clk_50M);
  endtask

  task automatic idle_chk(input string tag);
    #1;
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tx"}, tx, 1);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    repeat (3) @(negedge clk_50M);
    reset  = 1'b0;
    m_last = NREQ - 1;
    @(negedge clk_50M);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    do_reset();

    // Reset state
    idle_chk("rst");
    chk("rst_grant", grant_id, 0);

    // Single byte 0xA5 from requester 0
    req_data[7:0] = 8'hA5;
    req_valid     = 4'b0001;
    one_frame(1'b1, 1'b0);
    idle_chk("single_after");
    chk("single_gid", grant_id, 0);

    // Round-robin with all four requesting, each dropping after its ready
    do_reset();
    req_data  = $urandom;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) one_frame(1'b1, 1'b0);
    idle_chk("rr_after");

    // Fairness: 0 and 2 held continuously
    do_reset();
    req_data  = $urandom;
    req_valid = 4'b0101;
    for (int i = 0; i < 4; i++) one_frame(1'b0, 1'b0);
    req_valid = '0;
    idle_chk("fair_after");

    // Data stability: inputs scrambled during SEND
    req_data  = $urandom;
    req_valid = 4'b0010;
    one_frame(1'b1, 1'b1);
    if (req_valid == 4'b0000) req_valid = 4'b0001;
    one_frame(1'b1, 1'b0);
    req_valid = '0;
    idle_chk("stab_after");

    // Reset in the middle of data bit 4 (frame bit 5)
    req_data  = $urandom;
    req_valid = 4'b0100;
    #1;
    chk("mid_ready", req_ready, 4'b0100);
    @(posedge clk_50M);
    repeat (5*CLK_DIV + 2) @(negedge clk_50M);
    reset     = 1'b1;
    req_valid = '0;
    @(negedge clk_50M);
    chk("mid_tx", tx, 1);
    chk("mid_busy", busy, 0);
    chk("mid_gid", grant_id, 0);
    chk("mid_ready0", req_ready, 0);
    reset  = 1'b0;
    m_last = NREQ - 1;
    @(negedge clk_50M);
    idle_chk("mid_idle");
    req_data  = $urandom;
    req_valid = 4'b1100;
    one_frame(1'b1, 1'b0);
    one_frame(1'b1, 1'b0);
    req_valid = '0;
    idle_chk("mid_after");

    // Parity-sensitive byte
    req_data[15:8] = 8'h07;
    req_valid      = 4'b0010;
    one_frame(1'b1, 1'b0);
    idle_chk("par_after");

    // Randomized traffic
    for (int i = 0; i < 8; i++) begin
      req_data  = $urandom;
      req_valid = 4'($urandom_range(1, 15));
      one_frame(1'($urandom_range(0, 1)), 1'b0);
    end
    req_valid = '0;
    idle_chk("rand_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
